// File: rtl/drv_7seg_mux.sv
// Time-multiplexed common-cathode 7-segment driver with lamp test, blanking and frame-synced updates.
// Optional brightness PWM is enabled by defining DRV_7SEG_MUX_PWM_EN.
module drv_7seg_mux #(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned DIV    = 1024
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  lt,
  input  logic [DIGITS-1:0]     blank,
  input  logic                  load,
  input  logic [8*DIGITS-1:0]   inbus,
`ifdef DRV_7SEG_MUX_PWM_EN
  input  logic [3:0]            bright,
`endif
  output logic [7:0]            outbus,
  output logic [DIGITS-1:0]     dig_sel,
  output logic                  frame
);

  localparam int unsigned PW = $clog2(DIV);
  localparam int unsigned IW = $clog2(DIGITS);
  localparam logic [PW-1:0] PcntLast = PW'(DIV - 1);
  localparam logic [IW-1:0] IdxLast  = IW'(DIGITS - 1);

  logic [PW-1:0]         pcnt_q, pcnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [8*DIGITS-1:0]   pending_q, pending_d;
  logic [8*DIGITS-1:0]   display_q, display_d;
  logic [7:0]            outbus_q, outbus_d;
  logic [DIGITS-1:0]     dig_sel_q, dig_sel_d;
  logic                  frame_q, frame_d;

  logic                  slot_end;
  logic                  frame_end;
  logic [DIGITS-1:0]     digit_onehot;
  logic [7:0]            digit_byte;
  logic                  digit_blank;
  logic                  pwm_on;

  // Slot prescaler and digit index; both freeze while en is low.
  always_comb begin
    slot_end  = en && (pcnt_q == PcntLast);
    frame_end = slot_end && (idx_q == IdxLast);
    pcnt_d    = pcnt_q;
    idx_d     = idx_q;
    if (en) begin
      pcnt_d = slot_end ? '0 : pcnt_q + 1'b1;
      if (slot_end) begin
        idx_d = (idx_q == IdxLast) ? '0 : idx_q + 1'b1;
      end
    end
  end

  // Display only changes at the frame boundary; a coincident load goes straight through.
  always_comb begin
    pending_d = load ? inbus : pending_q;
    display_d = frame_end ? pending_d : display_q;
  end

  always_comb begin
    digit_onehot = '0;
    digit_byte   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        digit_onehot[i] = 1'b1;
        digit_byte      = display_q[8*i +: 8];
      end
    end
    digit_blank = |(blank & digit_onehot);
  end

`ifdef DRV_7SEG_MUX_PWM_EN
  logic [PW:0] pwm_limit;

  // On-window is (bright+1)/16 of the slot, measured from the start of the slot.
  always_comb begin
    pwm_limit = (PW+1)'(({1'b0, bright} + 5'd1) * (DIV / 16));
    pwm_on    = ({1'b0, pcnt_q} < pwm_limit);
  end
`else
  always_comb pwm_on = 1'b1;
`endif

  always_comb begin
    outbus_d  = '0;
    dig_sel_d = '0;
    frame_d   = frame_end;
    if (en) begin
      if (lt) begin
        outbus_d  = 8'hFF;
        dig_sel_d = digit_onehot;
      end else if (!digit_blank && pwm_on) begin
        outbus_d  = digit_byte;
        dig_sel_d = digit_onehot;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q    <= '0;
      idx_q     <= '0;
      pending_q <= '0;
      display_q <= '0;
      outbus_q  <= '0;
      dig_sel_q <= '0;
      frame_q   <= 1'b0;
    end else begin
      pcnt_q    <= pcnt_d;
      idx_q     <= idx_d;
      pending_q <= pending_d;
      display_q <= display_d;
      outbus_q  <= outbus_d;
      dig_sel_q <= dig_sel_d;
      frame_q   <= frame_d;
    end
  end

  assign outbus  = outbus_q;
  assign dig_sel = dig_sel_q;
  assign frame   = frame_q;

endmodule

// File: tb/tb_drv_7seg_mux.sv
// Self-checking bench for drv_7seg_mux (DIGITS=4, DIV=16) with a position-counter reference model.
// Exercises the brightness PWM as well when DRV_7SEG_MUX_PWM_EN is defined.
module tb_drv_7seg_mux;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned DIV    = 16;
  localparam int          FRAME  = DIGITS * DIV;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                lt = 1'b0;
  logic                load = 1'b0;
  logic [DIGITS-1:0]   blank = '0;
  logic [8*DIGITS-1:0] inbus = '0;
`ifdef DRV_7SEG_MUX_PWM_EN
  logic [3:0]          bright = 4'd15;
`endif
  logic [7:0]          outbus;
  logic [DIGITS-1:0]   dig_sel;
  logic                frame;

  int vectors = 0;
  int errors  = 0;

  always #5 clk = ~clk;

  drv_7seg_mux #(
    .DIGITS(DIGITS),
    .DIV   (DIV)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .en     (en),
    .lt     (lt),
    .blank  (blank),
    .load   (load),
    .inbus  (inbus),
`ifdef DRV_7SEG_MUX_PWM_EN
    .bright (bright),
`endif
    .outbus (outbus),
    .dig_sel(dig_sel),
    .frame  (frame)
  );

  // Reference model: one linear position within the frame plus byte arrays.
  int                m_pos;
  int                m_d;
  int                m_p;
  bit                m_bnd;
  bit                m_lit;
  logic [7:0]        m_pend[DIGITS];
  logic [7:0]        m_disp[DIGITS];
  logic [7:0]        m_out;
  logic [DIGITS-1:0] m_sel;
  logic              m_frame;

  always @(posedge clk) begin
    if (rst) begin
      m_pos   = 0;
      m_out   = '0;
      m_sel   = '0;
      m_frame = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        m_pend[i] = '0;
        m_disp[i] = '0;
      end
    end else begin
      m_d   = m_pos / DIV;
      m_p   = m_pos % DIV;
      m_bnd = en && (m_pos == FRAME - 1);
`ifdef DRV_7SEG_MUX_PWM_EN
      m_lit = (m_p < ((int'(bright) + 1) * DIV) / 16);
`else
      m_lit = 1'b1;
`endif
      m_out = '0;
      m_sel = '0;
      if (en && lt) begin
        m_out      = 8'hFF;
        m_sel[m_d] = 1'b1;
      end else if (en && !blank[m_d] && m_lit) begin
        m_out      = m_disp[m_d];
        m_sel[m_d] = 1'b1;
      end
      m_frame = m_bnd;
      if (m_bnd) begin
        for (int i = 0; i < DIGITS; i++) m_disp[i] = m_pend[i];
      end
      if (load) begin
        for (int i = 0; i < DIGITS; i++) begin
          m_pend[i] = inbus[8*i +: 8];
          if (m_bnd) m_disp[i] = inbus[8*i +: 8];
        end
      end
      if (en) m_pos = (m_pos + 1) % FRAME;
    end
  end

  function automatic logic [DIGITS-1:0] onehot(int d);
    logic [DIGITS-1:0] v;
    v    = '0;
    v[d] = 1'b1;
    return v;
  endfunction

  // Pulses rst for two edges; returns on the negedge where rst drops.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    en = 1'b1; lt = 1'b0; blank = '0; load = 1'b0;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++;
      if (outbus !== 8'h00 || dig_sel !== '0 || frame !== 1'b0) begin
        errors++;
        $display("FAIL reset c=%0d: outbus=%h dig_sel=%b frame=%b, want 00/0000/0",
                 c, outbus, dig_sel, frame);
      end
    end
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      vectors++;
      if (dig_sel !== onehot((k / DIV) % DIGITS)) begin
        errors++;
        $display("FAIL scan k=%0d: dig_sel=%b want %b", k, dig_sel, onehot((k / DIV) % DIGITS));
      end
      vectors++;
      if (outbus !== 8'h00) begin
        errors++;
        $display("FAIL scan_out k=%0d: outbus=%h want 00", k, outbus);
      end
      vectors++;
      if (frame !== (k == FRAME - 1)) begin
        errors++;
        $display("FAIL scan_frame k=%0d: frame=%b want %b", k, frame, (k == FRAME - 1));
      end
    end
  endtask

  task automatic test_load_frame();
    logic [31:0] d1, d2, cur;
    logic [7:0]  exp_out;
    int          d;
    d1 = 32'hF6FE60FC;
    d2 = $urandom;
    en = 1'b1; lt = 1'b0; blank = '0; load = 1'b0;
    do_reset();
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      d       = (k / DIV) % DIGITS;
      cur     = (k < 64) ? 32'h0 : ((k < 128) ? d1 : d2);
      exp_out = cur[8*d +: 8];
      vectors++;
      if (outbus !== exp_out || dig_sel !== onehot(d)) begin
        errors++;
        $display("FAIL load_frame k=%0d: outbus=%h dig_sel=%b want %h/%b",
                 k, outbus, dig_sel, exp_out, onehot(d));
      end
      vectors++;
      if (frame !== (k % FRAME == FRAME - 1)) begin
        errors++;
        $display("FAIL load_frame_pulse k=%0d: frame=%b want %b", k, frame, (k % FRAME == FRAME - 1));
      end
      load  = (k == 10) || (k == 80);
      inbus = (k == 10) ? d1 : ((k == 80) ? d2 : $urandom);
    end
    load = 1'b0;
  endtask

  task automatic test_lamp();
    logic [31:0]       data;
    logic [7:0]        exp_out;
    logic [DIGITS-1:0] exp_sel;
    int                d;
    data = $urandom;
    en = 1'b1; lt = 1'b1; blank = 4'b0101; load = 1'b0;
    do_reset();
    for (int k = 0; k < 128; k++) begin
      @(negedge clk);
      d = (k / DIV) % DIGITS;
      if (k < 64) begin
        exp_out = 8'hFF;
        exp_sel = onehot(d);
      end else if (blank[d]) begin
        exp_out = 8'h00;
        exp_sel = '0;
      end else begin
        exp_out = data[8*d +: 8];
        exp_sel = onehot(d);
      end
      vectors++;
      if (outbus !== exp_out || dig_sel !== exp_sel) begin
        errors++;
        $display("FAIL lamp k=%0d: outbus=%h dig_sel=%b want %h/%b",
                 k, outbus, dig_sel, exp_out, exp_sel);
      end
      load  = (k == 5);
      inbus = data;
      if (k == 63) lt = 1'b0;
    end
    load  = 1'b0;
    blank = '0;
  endtask

  task automatic test_boundary_load();
    logic [31:0] d1, d2;
    logic [7:0]  exp_out;
    int          d;
    d1 = $urandom;
    d2 = $urandom;
    d2[7:0] = 8'hDA;
    en = 1'b1; lt = 1'b0; blank = '0; load = 1'b0;
    do_reset();
    for (int k = 0; k < 96; k++) begin
      @(negedge clk);
      d       = (k / DIV) % DIGITS;
      exp_out = (k < 64) ? 8'h00 : d2[8*d +: 8];
      vectors++;
      if (outbus !== exp_out || dig_sel !== onehot(d)) begin
        errors++;
        $display("FAIL boundary_load k=%0d: outbus=%h dig_sel=%b want %h/%b",
                 k, outbus, dig_sel, exp_out, onehot(d));
      end
      vectors++;
      if (frame !== (k == 63)) begin
        errors++;
        $display("FAIL boundary_frame k=%0d: frame=%b want %b", k, frame, (k == 63));
      end
      load  = (k == 3) || (k == 62);
      inbus = (k == 3) ? d1 : d2;
    end
    load = 1'b0;
  endtask

  task automatic test_enable();
    logic [31:0]       data;
    logic [7:0]        exp_out;
    logic [DIGITS-1:0] exp_sel;
    logic              exp_frame;
    int                ph, cnt1;
    data = $urandom;
    cnt1 = 0;
    en = 1'b1; lt = 1'b0; blank = '0; load = 1'b0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (k >= 21 && k <= 25) begin
        exp_out   = 8'h00;
        exp_sel   = '0;
        exp_frame = 1'b0;
      end else begin
        ph        = (k >= 26) ? k - 5 : k;
        exp_sel   = onehot((ph / DIV) % DIGITS);
        exp_out   = (ph < 64) ? 8'h00 : data[8*((ph / DIV) % DIGITS) +: 8];
        exp_frame = (ph == 63);
      end
      if (k < 60 && dig_sel == 4'b0010) cnt1++;
      vectors++;
      if (outbus !== exp_out || dig_sel !== exp_sel || frame !== exp_frame) begin
        errors++;
        $display("FAIL enable k=%0d: outbus=%h dig_sel=%b frame=%b want %h/%b/%b",
                 k, outbus, dig_sel, frame, exp_out, exp_sel, exp_frame);
      end
      load  = (k == 2);
      inbus = data;
      en    = !(k >= 20 && k <= 24);
    end
    load = 1'b0;
    en   = 1'b1;
    vectors++;
    if (cnt1 !== 16) begin
      errors++;
      $display("FAIL enable_slot_len: digit1 selected %0d cycles, want 16", cnt1);
    end
  endtask

  task automatic test_midreset();
    logic [31:0] data;
    data = $urandom;
    en = 1'b1; lt = 1'b0; blank = '0; load = 1'b0;
    do_reset();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      load  = (k == 1);
      inbus = data;
    end
    vectors++;
    if (outbus !== data[23:16] || dig_sel !== 4'b0100) begin
      errors++;
      $display("FAIL midreset_pre: outbus=%h dig_sel=%b want %h/0100", outbus, dig_sel, data[23:16]);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (outbus !== 8'h00 || dig_sel !== '0 || frame !== 1'b0) begin
      errors++;
      $display("FAIL midreset: outbus=%h dig_sel=%b frame=%b want 00/0000/0", outbus, dig_sel, frame);
    end
    rst = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      vectors++;
      if (outbus !== 8'h00 || dig_sel !== onehot((k / DIV) % DIGITS) || frame !== (k == 63)) begin
        errors++;
        $display("FAIL midreset_after k=%0d: outbus=%h dig_sel=%b frame=%b want 00/%b/%b",
                 k, outbus, dig_sel, frame, onehot((k / DIV) % DIGITS), (k == 63));
      end
    end
  endtask

`ifdef DRV_7SEG_MUX_PWM_EN
  task automatic test_pwm();
    logic [31:0]       data;
    logic [7:0]        exp_out;
    logic [DIGITS-1:0] exp_sel;
    int                d, p, on0;
    bit                on;
    data = $urandom;
    on0  = 0;
    en = 1'b1; lt = 1'b0; blank = '0; load = 1'b0; bright = 4'd3;
    do_reset();
    for (int k = 0; k < 192; k++) begin
      @(negedge clk);
      d  = (k / DIV) % DIGITS;
      p  = k % DIV;
      on = (k >= 64) || (p < 4);
      exp_sel = on ? onehot(d) : '0;
      exp_out = !on ? 8'h00 : ((k >= 128) ? 8'hFF : ((k >= 64) ? data[8*d +: 8] : 8'h00));
      if (k < 16 && dig_sel[0]) on0++;
      vectors++;
      if (outbus !== exp_out || dig_sel !== exp_sel) begin
        errors++;
        $display("FAIL pwm k=%0d: outbus=%h dig_sel=%b want %h/%b", k, outbus, dig_sel, exp_out, exp_sel);
      end
      load  = (k == 0);
      inbus = data;
      if (k == 63) bright = 4'd15;
      if (k == 127) begin
        lt     = 1'b1;
        bright = 4'd0;
      end
    end
    lt     = 1'b0;
    bright = 4'd15;
    vectors++;
    if (on0 !== 4) begin
      errors++;
      $display("FAIL pwm_duty: digit0 on %0d cycles at bright=3, want 4", on0);
    end
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      vectors++;
      if (outbus !== m_out || dig_sel !== m_sel || frame !== m_frame) begin
        errors++;
        $display("FAIL random n=%0d: outbus=%h dig_sel=%b frame=%b want %h/%b/%b",
                 n, outbus, dig_sel, frame, m_out, m_sel, m_frame);
      end
      rst   = ($urandom_range(0, 299) == 0);
      en    = ($urandom_range(0, 9) != 0);
      lt    = ($urandom_range(0, 15) == 0);
      blank = ($urandom_range(0, 3) == 0) ? DIGITS'($urandom) : '0;
      load  = ($urandom_range(0, 7) == 0);
      inbus = $urandom;
`ifdef DRV_7SEG_MUX_PWM_EN
      bright = 4'($urandom);
`endif
    end
    rst = 1'b0; load = 1'b0; lt = 1'b0;
  endtask

  initial begin
    test_reset();
    test_load_frame();
    test_lamp();
    test_boundary_load();
    test_enable();
    test_midreset();
`ifdef DRV_7SEG_MUX_PWM_EN
    test_pwm();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/drv_7seg_mux.md
Name: drv_7seg_mux

Overview:
- Parametrised, time-multiplexed driver for a row of DIGITS common-cathode 7-segment digits.
- Takes pre-decoded segment patterns, one byte per digit, in the same encoding as the single-digit driver: bit7=a … bit1=g, bit0=dp, active-high.
- Scans one digit per slot and drives a shared segment bus plus a one-hot digit select.
- Adds lamp test, per-digit blanking, tear-free frame-synchronous updates, and an optional brightness PWM.
- Sits between the BCD/segment decoders and the board display pins.

Parameters:
- DIGITS, 4, number of multiplexed digits (2..8).
- DIV, 1024, clock cycles per digit slot (>=16; must be a multiple of 16).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, synchronous, active-high.
- en  in  1  scan enable; 0 freezes the scan and darkens the display.
- lt  in  1  lamp test; forces all segments on.
- blank  in  DIGITS  per-digit blank; bit i blanks digit i.
- load  in  1  one-cycle strobe; captures inbus into the pending register.
- inbus  in  8*DIGITS  segment patterns; digit i = inbus[8*i+7:8*i].
- outbus  out  8  shared segment bus, registered.
- dig_sel  out  DIGITS  one-hot digit enable, registered.
- frame  out  1  one-cycle pulse on the cycle the display register updates.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high. Every flop reaches its reset value on the first rising edge with rst=1, including mid-frame.
- Reset values:
  - outbus=0, dig_sel=0, frame=0.
  - Prescaler pcnt=0, digit index idx=0.
  - Pending and display registers all 0.
- Prescaler:
  - While en=1, pcnt counts 0..DIV-1 and then wraps to 0.
  - When pcnt=DIV-1, idx advances; it wraps from DIGITS-1 to 0.
  - While en=0, pcnt and idx hold.
- Frame boundary: the cycle with pcnt=DIV-1 and idx=DIGITS-1, with en=1.
  - On that edge, display <= pending and frame pulses high for one cycle.
- Load:
  - load=1 captures inbus into pending on the next edge.
  - If load coincides with a frame boundary, inbus is written into both pending and display on that edge, so the newest data wins.
  - Loads never alter display mid-frame, so there is no tearing.
- Output computation, registered with 1-cycle latency from the current (idx, pcnt, display, lt, blank, en):
  - en=0: outbus=0, dig_sel=0.
  - lt=1: outbus=8'hFF, dig_sel=one-hot(idx). lt overrides blank; scanning continues.
  - blank[idx]=1: outbus=0, dig_sel=0.
  - Otherwise: outbus=display byte idx, dig_sel=one-hot(idx).
- Scan timing:
  - Each digit is selected for exactly DIV consecutive cycles.
  - The frame period is DIGITS*DIV cycles.
  - At most one dig_sel bit is high in any cycle.
- Deassertion: when en goes 0, the outputs clear on the next edge. When en returns to 1, scanning resumes from the held pcnt/idx.

Optional Feature:
- Macro DRV_7SEG_MUX_PWM_EN.
- Defined:
  - Adds input port bright, 4 bits.
  - dig_sel and outbus are active only while pcnt < ((bright+1)*DIV)/16. Otherwise both are 0.
  - bright=15 gives the full slot; bright=0 gives DIV/16 cycles per slot.
  - bright is sampled every cycle.
  - lt ignores bright and always uses the full slot.
- Not defined:
  - No bright port.
  - The digit is active for the whole slot.

Test Plan:
- Reset, bench DIGITS=4, DIV=16:
  - Stimulus: rst=1 for 3 cycles, en=1.
  - Response: outbus=0, dig_sel=0 during reset. After release, dig_sel=0001 for 16 cycles, then 0010, 0100, 1000, then 0001 again. outbus=0 until the first frame pulse at cycle 64.
- Load and frame sync:
  - Stimulus: load inbus={8'hF6,8'hFE,8'h60,8'hFC} at cycle 10.
  - Response: outbus stays 0 until frame. After frame, digit0=FC, digit1=60, digit2=FE, digit3=F6.
  - Stimulus: a second load mid-frame.
  - Response: no change to outbus until the next frame.
- Lamp test:
  - Stimulus: lt=1 with blank=4'b0101.
  - Response: outbus=8'hFF on every slot, and dig_sel keeps scanning all 4 digits.
  - Stimulus: lt=0.
  - Response: digits 0 and 2 show dig_sel=0, outbus=0. Digits 1 and 3 show their patterns.
- Load at frame boundary:
  - Stimulus: load asserted on the pcnt=15, idx=3 cycle with inbus byte0=8'hDA.
  - Response: the very next digit0 slot shows DA, and frame=1 on that same edge.
- Enable gating and mid-operation reset:
  - Stimulus: en=0 mid-slot for 5 cycles.
  - Response: outputs 0, and after en=1 the same digit finishes its remaining cycles.
  - Stimulus: rst=1 mid-frame.
  - Response: all outputs and registers are 0 on the next edge.
- PWM, only with DRV_7SEG_MUX_PWM_EN:
  - Stimulus: bright=3, DIV=16.
  - Response: each dig_sel bit is high for 4 of its 16 cycles (pcnt 0..3).
  - Stimulus: bright=15.
  - Response: high for 16 of 16 cycles.
  - Stimulus: lt=1 with bright=0.
  - Response: high for 16 of 16 cycles.
